kinase_program_sequencer: RTL
=============================

KINASE_PROGRAM_SEQUENCER -- requirements
Module: kinase_program_sequencer

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 16, the depth of the step program memory.
REQ-002 SHALL have parameter DWELL_W, default 16, the width of the per-step dwell count.
REQ-003 SHALL have parameter DIV_W, default 12, the width of the pump phase divider.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk, input, 1, rising-edge clock for all state.
REQ-005 SHALL have rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have cfg_we, input, 1, write strobe for the step memory.
REQ-007 SHALL have cfg_addr, input, log2(NUM_STEPS), step memory write address.
REQ-008 SHALL have cfg_data, input, 19+DWELL_W, step word: [12:0] ctrl_a, [16:13] ctrl_s, [17] pump_a_en, [18] pump_b_en, [18+DWELL_W:19] dwell.
REQ-009 SHALL have cfg_last, input, 1, written alongside cfg_data; marks the step as the final step.
REQ-010 SHALL have start, input, 1, single-cycle request to run the program from step 0.
REQ-011 SHALL have abort, input, 1, single-cycle request to stop a running program.
REQ-012 SHALL have pump_div, input, DIV_W, pump phase period minus one, in cycles.
REQ-013 SHALL have ctrl_a, output, 13, valve drive; ctrl_s, output, 4, valve drive.
REQ-014 SHALL have pump_a, output, 3, 3-valve peristaltic drive; pump_b, output, 2, 2-valve pump drive.
REQ-015 SHALL have busy, done, aborted, each output, 1; step_idx, output, log2(NUM_STEPS), current step.

Function
REQ-016 SHALL implement states IDLE, RUN, FINISH; all outputs registered.
REQ-017 SHALL write cfg_data/cfg_last into the step at cfg_addr on cfg_we only in IDLE; writes in RUN/FINISH are ignored.
REQ-018 SHALL, on start in IDLE without abort, enter RUN with step_idx=0; on the next cycle ctrl_a/ctrl_s equal step 0 fields and busy=1.
REQ-019 SHALL hold each step for exactly dwell+1 cycles (dwell=0 gives 1 cycle); then advance step_idx by 1 and present the next step's fields with no gap cycle.
REQ-020 SHALL go to FINISH after a step marked last, or after step NUM_STEPS-1, completes its dwell; step_idx does not wrap.
REQ-021 SHALL in FINISH drive all valve/pump outputs to 0, pulse done=1 for one cycle, deassert busy, and return to IDLE.
REQ-022 SHALL, with pump_a_en=1, cycle pump_a through 100,110,010,011,001,101 then repeat, advancing one phase every pump_div+1 cycles.
REQ-023 SHALL, with pump_b_en=1, alternate pump_b between 01 and 10 on the same phase tick as pump_a.
REQ-024 SHALL drive a disabled pump to 000/00; the phase counter and divider restart at phase 0 at every step entry.
REQ-025 SHALL, on abort in RUN, next cycle drive all valve/pump outputs to 0, busy=0, pulse aborted=1 for one cycle, enter IDLE, and not pulse done.
REQ-026 SHALL give abort priority over start in the same cycle; start in RUN/FINISH and abort in IDLE are ignored.
REQ-027 SHALL sample pump_div at step entry; changes mid-step take effect at the next step.

Reset
REQ-028 SHALL on rst enter IDLE, with ctrl_a, ctrl_s, pump_a, pump_b, busy, done, aborted and step_idx all 0, including mid-run.
REQ-029 SHALL leave step memory contents unchanged on rst; a later start runs the previously loaded program.

Verification
REQ-030 SHALL cover: load 3 steps (ctrl_a 0x001/0x002/0x004, dwell 2/0/5, step 2 last), start -> ctrl_a 0x001 for 3 cycles, 0x002 for 1, 0x004 for 6, then one-cycle done.
REQ-031 SHALL cover: step with pump_a_en=1, pump_div=1, dwell 11 -> pump_a 100,100,110,110,010,010,011,011,001,001,101,101.
REQ-032 SHALL cover: abort during step 1 -> next cycle outputs 0, aborted=1, done stays 0, busy=0.
REQ-033 SHALL cover: start and abort asserted together in IDLE -> busy stays 0 and no pulse.
REQ-034 SHALL cover: rst mid-run -> all outputs 0 next cycle; new start replays the stored program unchanged.
REQ-035 SHALL cover: all NUM_STEPS steps loaded with no last flag -> runs steps 0..15, then done, with no wrap to step 0.

Source files
------------

// File: rtl/kinase_program_sequencer.sv
// Purpose : steps through a stored valve/pump program, holding each step for
//           its programmed dwell and sequencing two peristaltic pump drives.
// Latency : all outputs are registered. Step 0 is driven one cycle after start.
//           Each step lasts dwell+1 cycles, and steps follow with no gap cycle.
// Backpressure: none. Config writes outside IDLE are dropped. start is honoured
//           only in IDLE, abort only in RUN, and abort beats start.
// Ports   : clk/rst (sync, active-high); cfg_we/cfg_addr/cfg_data/cfg_last
//           program load; start/abort run control; pump_div pump phase period-1;
//           ctrl_a/ctrl_s valve drive; pump_a/pump_b pump drive;
//           busy/done/aborted status; step_idx current step.
module kinase_program_sequencer #(
  parameter int NUM_STEPS = 16,
  parameter int DWELL_W   = 16,
  parameter int DIV_W     = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_STEPS)-1:0] cfg_addr,
  input  logic [19+DWELL_W-1:0]        cfg_data,
  input  logic                         cfg_last,
  input  logic                         start,
  input  logic                         abort,
  input  logic [DIV_W-1:0]             pump_div,
  output logic [12:0]                  ctrl_a,
  output logic [3:0]                   ctrl_s,
  output logic [2:0]                   pump_a,
  output logic [1:0]                   pump_b,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx
);

  localparam int AW = $clog2(NUM_STEPS);
  localparam int CW = 19 + DWELL_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  // Step memory: no reset, so a stored program survives rst.
  logic [CW-1:0]        mem_data_q [NUM_STEPS];
  logic [NUM_STEPS-1:0] mem_last_q;

  state_t               state_q, state_d;
  logic [AW-1:0]        step_idx_q, step_idx_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DIV_W-1:0]     div_q, div_d;          // pump_div captured at step entry
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [2:0]           phase_q, phase_d;
  logic                 pa_en_q, pa_en_d, pb_en_q, pb_en_d;
  logic [12:0]          ctrl_a_q, ctrl_a_d;
  logic [3:0]           ctrl_s_q, ctrl_s_d;
  logic [2:0]           pump_a_q, pump_a_d;
  logic [1:0]           pump_b_q, pump_b_d;
  logic                 busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;

  logic                 ld;
  logic [AW-1:0]        ld_idx;
  logic [CW-1:0]        ld_word;

  function automatic logic [2:0] pump_a_pat(input logic [2:0] ph);
    case (ph)
      3'd0:    return 3'b100;
      3'd1:    return 3'b110;
      3'd2:    return 3'b010;
      3'd3:    return 3'b011;
      3'd4:    return 3'b001;
      3'd5:    return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (cfg_we && state_q == S_IDLE) begin
      mem_data_q[cfg_addr] <= cfg_data;
      mem_last_q[cfg_addr] <= cfg_last;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_idx_d = step_idx_q;
    dwell_d    = dwell_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;
    phase_d    = phase_q;
    pa_en_d    = pa_en_q;
    pb_en_d    = pb_en_q;
    ctrl_a_d   = ctrl_a_q;
    ctrl_s_d   = ctrl_s_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    ld         = 1'b0;
    ld_idx     = '0;
    ld_word    = '0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_RUN;
          ld      = 1'b1;
          ld_idx  = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          ctrl_a_d  = '0;
          ctrl_s_d  = '0;
          pa_en_d   = 1'b0;
          pb_en_d   = 1'b0;
          aborted_d = 1'b1;
        end else if (dwell_q == '0) begin
          // Final cycle of this step: finish or move straight to the next one.
          if (mem_last_q[step_idx_q] || step_idx_q == AW'(NUM_STEPS - 1)) begin
            state_d  = S_FINISH;
            busy_d   = 1'b0;
            ctrl_a_d = '0;
            ctrl_s_d = '0;
            pa_en_d  = 1'b0;
            pb_en_d  = 1'b0;
            done_d   = 1'b1;
          end else begin
            ld     = 1'b1;
            ld_idx = step_idx_q + 1'b1;
          end
        end else begin
          dwell_d = dwell_q - 1'b1;
          if (div_cnt_q == div_q) begin
            div_cnt_d = '0;
            phase_d   = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Step entry: fetch the word, restart the pump phase/divider, and capture pump_div.
    if (ld) begin
      ld_word    = mem_data_q[ld_idx];
      step_idx_d = ld_idx;
      ctrl_a_d   = ld_word[12:0];
      ctrl_s_d   = ld_word[16:13];
      pa_en_d    = ld_word[17];
      pb_en_d    = ld_word[18];
      dwell_d    = ld_word[CW-1:19];
      div_d      = pump_div;
      div_cnt_d  = '0;
      phase_d    = 3'd0;
      busy_d     = 1'b1;
    end

    // pump_b toggles with phase parity. Six phases keep it alternating across the wrap.
    pump_a_d = (busy_d && pa_en_d) ? pump_a_pat(phase_d) : 3'b000;
    pump_b_d = (busy_d && pb_en_d) ? (phase_d[0] ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_idx_q <= '0;
      dwell_q    <= '0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      phase_q    <= '0;
      pa_en_q    <= 1'b0;
      pb_en_q    <= 1'b0;
      ctrl_a_q   <= '0;
      ctrl_s_q   <= '0;
      pump_a_q   <= '0;
      pump_b_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_idx_q <= step_idx_d;
      dwell_q    <= dwell_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      phase_q    <= phase_d;
      pa_en_q    <= pa_en_d;
      pb_en_q    <= pb_en_d;
      ctrl_a_q   <= ctrl_a_d;
      ctrl_s_q   <= ctrl_s_d;
      pump_a_q   <= pump_a_d;
      pump_b_q   <= pump_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign ctrl_a   = ctrl_a_q;
  assign ctrl_s   = ctrl_s_q;
  assign pump_a   = pump_a_q;
  assign pump_b   = pump_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign step_idx = step_idx_q;

endmodule
